mem_arbiter: RTL and testbench

//  Shares the single external memory port between the instruction cache (ic_*) and data cache (dc_*).

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_owner_fifo.sv | 46 ++++
 rtl/mem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the I/D-cache memory arbiter.
// Owner ids are also the values stored in the outstanding-read FIFO.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_BITS = 28;
  localparam int unsigned DATA_BITS = 128;
  localparam int unsigned MASK_BITS = DATA_BITS / 8;
  localparam int unsigned BEATS     = 4;
  localparam int unsigned MAX_OUTST = 4;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StReqLock,
    StDataLock
  } arb_state_e;

  typedef struct packed {
    logic                 valid;
    logic [ADDR_BITS-1:0] addr;
    logic                 rw;
    logic                 data_valid;
    logic [DATA_BITS-1:0] data_bits;
    logic [MASK_BITS-1:0] data_mask;
  } mem_req_t;

endpackage

// File: rtl/mem_owner_fifo.sv
// 1-bit synchronous FIFO holding the owner of each outstanding read.
// A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
module mem_owner_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_owner,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrBits = $clog2(Depth);
  localparam logic [PtrBits:0] PtrOne = (PtrBits + 1)'(1);

  logic [Depth-1:0] mem_q;
  logic [PtrBits:0] wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PtrBits] != rd_q[PtrBits]) &&
                   (wr_q[PtrBits-1:0] == rd_q[PtrBits-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q[PtrBits-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[PtrBits-1:0]] <= push_owner;
        wr_q                     <= wr_q + PtrOne;
      end
      if (do_pop) begin
        rd_q <= rd_q + PtrOne;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I-cache and D-cache: round-robin grant locked until
// the request (and write data) handshake, read responses steered back by an owner FIFO.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ic_mem_req_valid,
  output logic                 ic_mem_req_ready,
  input  logic [ADDR_BITS-1:0] ic_mem_req_addr,
  input  logic                 ic_mem_req_rw,
  input  logic                 ic_mem_req_data_valid,
  output logic                 ic_mem_req_data_ready,
  input  logic [DATA_BITS-1:0] ic_mem_req_data_bits,
  input  logic [MASK_BITS-1:0] ic_mem_req_data_mask,
  output logic                 ic_mem_resp_valid,
  output logic [DATA_BITS-1:0] ic_mem_resp_data,
  input  logic                 dc_mem_req_valid,
  output logic                 dc_mem_req_ready,
  input  logic [ADDR_BITS-1:0] dc_mem_req_addr,
  input  logic                 dc_mem_req_rw,
  input  logic                 dc_mem_req_data_valid,
  output logic                 dc_mem_req_data_ready,
  input  logic [DATA_BITS-1:0] dc_mem_req_data_bits,
  input  logic [MASK_BITS-1:0] dc_mem_req_data_mask,
  output logic                 dc_mem_resp_valid,
  output logic [DATA_BITS-1:0] dc_mem_resp_data,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic                 mem_req_rw,
  output logic                 mem_req_data_valid,
  input  logic                 mem_req_data_ready,
  output logic [DATA_BITS-1:0] mem_req_data_bits,
  output logic [MASK_BITS-1:0] mem_req_data_mask,
  input  logic                 mem_resp_valid,
  input  logic [DATA_BITS-1:0] mem_resp_data
);

  localparam int unsigned BeatBits = $clog2(BEATS);
  localparam logic [BeatBits-1:0] BeatLast = BeatBits'(BEATS - 1);
  localparam logic [BeatBits-1:0] BeatOne  = BeatBits'(1);

  arb_state_e          st_q, st_d;
  logic                grant_q, grant_d, rr_q, rr_d, data_done_q, data_done_d;
  logic [BeatBits-1:0] beat_q, beat_d;
  mem_req_t            req_ic, req_dc, req_sel;
  logic                sel, req_phase, data_phase, fwd_data, stall;
  logic                req_fire, data_fire, resp_hit, push, pop;
  logic                fifo_head, fifo_full, fifo_empty;

  assign req_ic = '{valid: ic_mem_req_valid, addr: ic_mem_req_addr, rw: ic_mem_req_rw,
                    data_valid: ic_mem_req_data_valid, data_bits: ic_mem_req_data_bits,
                    data_mask: ic_mem_req_data_mask};
  assign req_dc = '{valid: dc_mem_req_valid, addr: dc_mem_req_addr, rw: dc_mem_req_rw,
                    data_valid: dc_mem_req_data_valid, data_bits: dc_mem_req_data_bits,
                    data_mask: dc_mem_req_data_mask};
  assign req_sel = (sel == OWNER_DC) ? req_dc : req_ic;

  always_comb begin
    sel        = grant_q;
    req_phase  = 1'b0;
    data_phase = 1'b0;
    unique case (st_q)
      StIdle: begin
        req_phase = ic_mem_req_valid | dc_mem_req_valid;
        if (ic_mem_req_valid && dc_mem_req_valid) sel = rr_q;
        else                                      sel = dc_mem_req_valid ? OWNER_DC : OWNER_IC;
      end
      StReqLock:  req_phase  = 1'b1;
      StDataLock: data_phase = 1'b1;
      default: ;
    endcase
  end

  // Write data is not re-sent once it was taken ahead of the request handshake.
  assign fwd_data  = data_phase | (req_phase & req_sel.rw & ~data_done_q);
  assign resp_hit  = ~reset & mem_resp_valid & ~fifo_empty;
  assign pop       = resp_hit & (beat_q == BeatLast);
  assign stall     = req_phase & ~req_sel.rw & fifo_full & ~pop;
  assign req_fire  = ~reset & req_phase & req_sel.valid & ~stall & mem_req_ready;
  assign data_fire = ~reset & fwd_data & req_sel.data_valid & mem_req_data_ready;
  assign push      = req_fire & ~req_sel.rw;

  always_comb begin
    st_d        = st_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    data_done_d = data_done_q;
    beat_d      = beat_q;
    if (req_phase) begin
      grant_d = sel;
      if (req_fire) begin
        rr_d        = ~rr_q;
        data_done_d = 1'b0;
        st_d        = (req_sel.rw && !data_done_q && !data_fire) ? StDataLock : StIdle;
      end else begin
        st_d = StReqLock;
        if (data_fire) data_done_d = 1'b1;
      end
    end else if (data_phase && data_fire) begin
      st_d = StIdle;
    end
    if (resp_hit) beat_d = beat_q + BeatOne;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= StIdle;
      grant_q     <= OWNER_IC;
      rr_q        <= OWNER_DC;
      data_done_q <= 1'b0;
      beat_q      <= '0;
    end else begin
      st_q        <= st_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      data_done_q <= data_done_d;
      beat_q      <= beat_d;
    end
  end

  mem_owner_fifo #(
    .Depth(MAX_OUTST)
  ) u_owner_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_owner(sel),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    mem_req_valid         = 1'b0;
    mem_req_addr          = '0;
    mem_req_rw            = 1'b0;
    mem_req_data_valid    = 1'b0;
    mem_req_data_bits     = '0;
    mem_req_data_mask     = '0;
    ic_mem_req_ready      = 1'b0;
    dc_mem_req_ready      = 1'b0;
    ic_mem_req_data_ready = 1'b0;
    dc_mem_req_data_ready = 1'b0;
    ic_mem_resp_valid     = 1'b0;
    dc_mem_resp_valid     = 1'b0;
    ic_mem_resp_data      = '0;
    dc_mem_resp_data      = '0;
    if (!reset) begin
      mem_req_valid = req_phase & req_sel.valid & ~stall;
      if (req_phase) begin
        mem_req_addr = req_sel.addr;
        mem_req_rw   = req_sel.rw;
      end
      if (fwd_data) begin
        mem_req_data_valid = req_sel.data_valid;
        mem_req_data_bits  = req_sel.data_bits;
        mem_req_data_mask  = req_sel.data_mask;
      end
      ic_mem_req_ready      = req_fire & (sel == OWNER_IC);
      dc_mem_req_ready      = req_fire & (sel == OWNER_DC);
      ic_mem_req_data_ready = data_fire & (sel == OWNER_IC);
      dc_mem_req_data_ready = data_fire & (sel == OWNER_DC);
      ic_mem_resp_valid     = resp_hit & (fifo_head == OWNER_IC);
      dc_mem_resp_valid     = resp_hit & (fifo_head == OWNER_DC);
      ic_mem_resp_data      = mem_resp_data;
      dc_mem_resp_data      = mem_resp_data;
    end
  end

  // A beat with nothing outstanding is dropped; flag it so protocol errors are visible.
  assert property (@(posedge clk) disable iff (reset) !(mem_resp_valid && fifo_empty))
    else $warning("mem_arbiter: response beat with no outstanding read dropped");

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven grant/pass-through vectors, directed multi-cycle
// sequences, and a randomized run against a memory model and scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_mem_req_valid, ic_mem_req_ready, ic_mem_req_rw;
  logic [27:0]  ic_mem_req_addr;
  logic         ic_mem_req_data_valid, ic_mem_req_data_ready;
  logic [127:0] ic_mem_req_data_bits;
  logic [15:0]  ic_mem_req_data_mask;
  logic         ic_mem_resp_valid;
  logic [127:0] ic_mem_resp_data;
  logic         dc_mem_req_valid, dc_mem_req_ready, dc_mem_req_rw;
  logic [27:0]  dc_mem_req_addr;
  logic         dc_mem_req_data_valid, dc_mem_req_data_ready;
  logic [127:0] dc_mem_req_data_bits;
  logic [15:0]  dc_mem_req_data_mask;
  logic         dc_mem_resp_valid;
  logic [127:0] dc_mem_resp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic         mem_req_data_valid, mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic [15:0]  mem_req_data_mask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
    .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_req_rw(ic_mem_req_rw),
    .ic_mem_req_data_valid(ic_mem_req_data_valid),
    .ic_mem_req_data_ready(ic_mem_req_data_ready),
    .ic_mem_req_data_bits(ic_mem_req_data_bits), .ic_mem_req_data_mask(ic_mem_req_data_mask),
    .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
    .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
    .dc_mem_req_addr(dc_mem_req_addr), .dc_mem_req_rw(dc_mem_req_rw),
    .dc_mem_req_data_valid(dc_mem_req_data_valid),
    .dc_mem_req_data_ready(dc_mem_req_data_ready),
    .dc_mem_req_data_bits(dc_mem_req_data_bits), .dc_mem_req_data_mask(dc_mem_req_data_mask),
    .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  localparam logic [127:0] IC_D = {4{32'h1111_1111}};
  localparam logic [127:0] DC_D = {4{32'h2222_2222}};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {127'b0, act}, {127'b0, exp});
  endtask

  task automatic chka(input string name, input logic [27:0] act, input logic [27:0] exp);
    chk(name, {100'b0, act}, {100'b0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_mem_req_valid = 0; ic_mem_req_rw = 0; ic_mem_req_addr = '0;
    ic_mem_req_data_valid = 0; ic_mem_req_data_bits = '0; ic_mem_req_data_mask = '0;
    dc_mem_req_valid = 0; dc_mem_req_rw = 0; dc_mem_req_addr = '0;
    dc_mem_req_data_valid = 0; dc_mem_req_data_bits = '0; dc_mem_req_data_mask = '0;
    mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ctl"}, {116'b0, ic_mem_req_ready, ic_mem_req_data_ready, ic_mem_resp_valid,
        dc_mem_req_ready, dc_mem_req_data_ready, dc_mem_resp_valid, mem_req_valid, mem_req_rw,
        mem_req_data_valid, 3'b0}, '0);
    chka({tag, " addr"}, mem_req_addr, '0);
    chk({tag, " wdata"}, mem_req_data_bits, '0);
    chk({tag, " mask"}, {112'b0, mem_req_data_mask}, '0);
    chk({tag, " ic rdata"}, ic_mem_resp_data, '0);
    chk({tag, " dc rdata"}, dc_mem_resp_data, '0);
  endtask

  task automatic resp_beat(input string tag, input logic to_dc, input logic [127:0] d);
    mem_resp_valid = 1; mem_resp_data = d;
    #1;
    chk1({tag, " ic resp_valid"}, ic_mem_resp_valid, !to_dc);
    chk1({tag, " dc resp_valid"}, dc_mem_resp_valid, to_dc);
    chk({tag, " resp data"}, to_dc ? dc_mem_resp_data : ic_mem_resp_data, d);
    step();
    mem_resp_valid = 0;
  endtask

  // in : {icv, icrw, icdv, dcv, dcrw, dcdv, mrdy, mdrdy}
  // ctl: {mv, mrw, mdv, icr, dcr, icdr, dcdr, 0}
  typedef struct {
    logic [7:0]   in;
    logic [7:0]   ctl;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [127:0] wdat(input logic [27:0] a);
    return {4'h0, a, 4'h0, a, 4'h0, a, 4'h0, a};
  endfunction

  function automatic logic [127:0] bdat(input logic [27:0] a, input logic [3:0] b);
    return {a, b, 96'h5A};
  endfunction

  typedef struct {
    logic        pend;
    logic        dpend;
    logic        rw;
    logic [27:0] addr;
  } rq_t;

  initial begin
    rq_t         rq[2];
    logic [27:0] rd_q[$];
    int          beat, outst, seqn;
    int          issued[2], accepted[2], rd_issued[2], rd_done[2], wr_issued[2], wr_done[2];
    logic        own;
    logic [7:0]  c;

    reset = 1;
    idle_inputs();
    step();
    step();
    reset = 0;
    #1;
    check_zero("reset");

    vecs[0] = '{8'b0000_0000, 8'b0000_0000, 28'h0,  128'h0, 16'h0};
    vecs[1] = '{8'b1000_0010, 8'b1001_0000, 28'h40, 128'h0, 16'h0};
    vecs[2] = '{8'b1000_0000, 8'b1000_0000, 28'h40, 128'h0, 16'h0};
    vecs[3] = '{8'b0001_0010, 8'b1000_1000, 28'h80, 128'h0, 16'h0};
    vecs[4] = '{8'b1001_0010, 8'b1000_1000, 28'h80, 128'h0, 16'h0};
    vecs[5] = '{8'b0001_1111, 8'b1110_1010, 28'h80, DC_D,   16'hFFFF};
    vecs[6] = '{8'b1110_0001, 8'b1110_0100, 28'h40, IC_D,   16'h00FF};
    vecs[7] = '{8'b1111_0010, 8'b1000_1000, 28'h80, 128'h0, 16'h0};
    vecs[8] = '{8'b1010_0011, 8'b1001_0000, 28'h40, 128'h0, 16'h0};

    for (int i = 0; i < 9; i++) begin
      do_reset();
      {ic_mem_req_valid, ic_mem_req_rw, ic_mem_req_data_valid, dc_mem_req_valid,
       dc_mem_req_rw, dc_mem_req_data_valid, mem_req_ready, mem_req_data_ready} = vecs[i].in;
      ic_mem_req_addr = 28'h40; ic_mem_req_data_bits = IC_D; ic_mem_req_data_mask = 16'h00FF;
      dc_mem_req_addr = 28'h80; dc_mem_req_data_bits = DC_D; dc_mem_req_data_mask = 16'hFFFF;
      #1;
      c = {mem_req_valid, mem_req_rw, mem_req_data_valid, ic_mem_req_ready, dc_mem_req_ready,
           ic_mem_req_data_ready, dc_mem_req_data_ready, 1'b0};
      chk($sformatf("vec%0d ctl", i), {120'b0, c}, {120'b0, vecs[i].ctl});
      chka($sformatf("vec%0d addr", i), mem_req_addr, vecs[i].addr);
      chk($sformatf("vec%0d wdata", i), mem_req_data_bits, vecs[i].data);
      chk($sformatf("vec%0d mask", i), {112'b0, mem_req_data_mask}, {112'b0, vecs[i].mask});
    end

    // Single I-cache read and its four beats.
    do_reset();
    ic_mem_req_valid = 1; ic_mem_req_addr = 28'h0000040; mem_req_ready = 1;
    #1;
    chk1("s1 mem_req_valid", mem_req_valid, 1);
    chka("s1 mem_req_addr", mem_req_addr, 28'h0000040);
    chk1("s1 mem_req_rw", mem_req_rw, 0);
    chk1("s1 ic ready", ic_mem_req_ready, 1);
    step();
    ic_mem_req_valid = 0; mem_req_ready = 0;
    for (int b = 0; b < 4; b++) resp_beat($sformatf("s1 beat%0d", b), 0, bdat(28'h40, 4'(b)));
    #1;
    chk1("s1 fifo empty", dut.fifo_empty, 1);

    // Simultaneous requests: dc first after reset, then ic; responses in order.
    do_reset();
    ic_mem_req_valid = 1; ic_mem_req_addr = 28'h100;
    dc_mem_req_valid = 1; dc_mem_req_addr = 28'h200; mem_req_ready = 1;
    #1;
    chk1("s2 dc ready first", dc_mem_req_ready, 1);
    chk1("s2 ic waits", ic_mem_req_ready, 0);
    chka("s2 first addr", mem_req_addr, 28'h200);
    step();
    dc_mem_req_valid = 0;
    #1;
    chk1("s2 ic ready second", ic_mem_req_ready, 1);
    chka("s2 second addr", mem_req_addr, 28'h100);
    step();
    ic_mem_req_valid = 0; mem_req_ready = 0;
    for (int b = 0; b < 8; b++)
      resp_beat($sformatf("s2 beat%0d", b), b < 4, bdat(28'h300, 4'(b)));

    // D-cache write with data held off for three cycles blocks the I-cache.
    do_reset();
    dc_mem_req_valid = 1; dc_mem_req_rw = 1; dc_mem_req_addr = 28'h80;
    dc_mem_req_data_valid = 1; dc_mem_req_data_bits = DC_D; dc_mem_req_data_mask = 16'hFFFF;
    ic_mem_req_valid = 1; ic_mem_req_addr = 28'h40; mem_req_ready = 1;
    #1;
    chk1("s3 dc req ready", dc_mem_req_ready, 1);
    chk1("s3 mem rw", mem_req_rw, 1);
    chk("s3 mask", {112'b0, mem_req_data_mask}, {112'b0, 16'hFFFF});
    chk1("s3 dc data ready low", dc_mem_req_data_ready, 0);
    step();
    dc_mem_req_valid = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk1($sformatf("s3 lock%0d no req", k), mem_req_valid, 0);
      chk1($sformatf("s3 lock%0d ic blocked", k), ic_mem_req_ready, 0);
      chk1($sformatf("s3 lock%0d data fwd", k), mem_req_data_valid, 1);
      step();
    end
    mem_req_data_ready = 1;
    #1;
    chk1("s3 dc data ready", dc_mem_req_data_ready, 1);
    chk1("s3 ic still blocked", ic_mem_req_ready, 0);
    chk("s3 wdata", mem_req_data_bits, DC_D);
    step();
    dc_mem_req_data_valid = 0; mem_req_data_ready = 0;
    #1;
    chk1("s3 ic granted", ic_mem_req_ready, 1);
    chka("s3 ic addr", mem_req_addr, 28'h40);

    // Owner FIFO full: fifth read waits for the last beat of the first read.
    do_reset();
    ic_mem_req_valid = 1; ic_mem_req_addr = 28'h500; mem_req_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1($sformatf("s4 read%0d accepted", k), ic_mem_req_ready, 1);
      step();
    end
    #1;
    chk1("s4 fifth stalls", ic_mem_req_ready, 0);
    chk1("s4 fifth mem valid", mem_req_valid, 0);
    step();
    for (int b = 0; b < 3; b++) begin
      mem_resp_valid = 1; mem_resp_data = bdat(28'h500, 4'(b));
      #1;
      chk1($sformatf("s4 beat%0d still stalled", b), ic_mem_req_ready, 0);
      chk1($sformatf("s4 beat%0d to ic", b), ic_mem_resp_valid, 1);
      step();
    end
    mem_resp_data = bdat(28'h500, 4'd3);
    #1;
    chk1("s4 accepted on last beat", ic_mem_req_ready, 1);
    chk1("s4 last beat to ic", ic_mem_resp_valid, 1);
    step();
    ic_mem_req_valid = 0; mem_resp_valid = 0;
    for (int b = 0; b < 16; b++) resp_beat($sformatf("s4 drain%0d", b), 0, bdat(28'h5, 4'(b)));
    #1;
    chk1("s4 fifo empty", dut.fifo_empty, 1);

    // Reset during REQ_LOCK with two reads outstanding.
    do_reset();
    ic_mem_req_valid = 1; ic_mem_req_addr = 28'h600; mem_req_ready = 1;
    step();
    step();
    ic_mem_req_valid = 0; dc_mem_req_valid = 1; dc_mem_req_addr = 28'h700; mem_req_ready = 0;
    #1;
    chk1("s5 dc not accepted", dc_mem_req_ready, 0);
    step();
    chk1("s5 in req lock", dut.st_q == StReqLock, 1);
    reset = 1; mem_resp_data = 128'hDEAD;
    #1;
    check_zero("s5 during reset");
    step();
    reset = 0;
    idle_inputs();
    #1;
    check_zero("s5 after reset");
    for (int b = 0; b < 4; b++) begin
      mem_resp_valid = 1; mem_resp_data = bdat(28'h600, 4'(b));
      #1;
      chk1($sformatf("s5 drop%0d ic", b), ic_mem_resp_valid, 0);
      chk1($sformatf("s5 drop%0d dc", b), dc_mem_resp_valid, 0);
      step();
    end
    mem_resp_valid = 0;

    // Randomized traffic against a memory model.
    do_reset();
    beat = 0; outst = 0; seqn = 0;
    for (int s = 0; s < 2; s++) begin
      rq[s] = '{1'b0, 1'b0, 1'b0, 28'h0};
      issued[s] = 0; accepted[s] = 0; rd_issued[s] = 0; rd_done[s] = 0;
      wr_issued[s] = 0; wr_done[s] = 0;
    end
    for (int cyc = 0; cyc < 10300; cyc++) begin
      bit gen;
      gen = (cyc < 10000);
      if (!gen && rd_q.size() == 0 && !rq[0].pend && !rq[0].dpend && !rq[1].pend &&
          !rq[1].dpend) break;
      for (int s = 0; s < 2; s++) begin
        if (gen && !rq[s].pend && !rq[s].dpend && $urandom_range(0, 2) == 0) begin
          seqn++;
          rq[s].addr  = {1'(s), 27'(seqn)};
          rq[s].rw    = ($urandom_range(0, 2) == 0);
          rq[s].pend  = 1;
          rq[s].dpend = rq[s].rw;
          issued[s]++;
          if (rq[s].rw) wr_issued[s]++;
        end
      end
      ic_mem_req_valid = rq[0].pend; ic_mem_req_addr = rq[0].addr; ic_mem_req_rw = rq[0].rw;
      ic_mem_req_data_valid = rq[0].dpend; ic_mem_req_data_bits = wdat(rq[0].addr);
      ic_mem_req_data_mask = rq[0].addr[15:0];
      dc_mem_req_valid = rq[1].pend; dc_mem_req_addr = rq[1].addr; dc_mem_req_rw = rq[1].rw;
      dc_mem_req_data_valid = rq[1].dpend; dc_mem_req_data_bits = wdat(rq[1].addr);
      dc_mem_req_data_mask = rq[1].addr[15:0];
      mem_req_ready      = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_req_data_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_resp_valid     = (rd_q.size() > 0) && (gen ? ($urandom_range(0, 2) != 0) : 1'b1);
      mem_resp_data      = (rd_q.size() > 0) ? bdat(rd_q[0], 4'(beat)) : '0;
      #1;
      if (mem_resp_valid) begin
        own = rd_q[0][27];
        chk1("rnd resp ic", ic_mem_resp_valid, !own);
        chk1("rnd resp dc", dc_mem_resp_valid, own);
        chk("rnd resp data", own ? dc_mem_resp_data : ic_mem_resp_data, mem_resp_data);
        beat++;
        if (beat == BEATS) begin
          beat = 0;
          void'(rd_q.pop_front());
          outst--;
          rd_done[own]++;
        end
      end else if (ic_mem_resp_valid || dc_mem_resp_valid) begin
        chk1("rnd spurious resp", 1'b1, 1'b0);
      end
      if (mem_req_valid && mem_req_ready) begin
        own = mem_req_addr[27];
        chk1("rnd req pending", rq[own].pend, 1);
        chk1("rnd owner ready", own ? dc_mem_req_ready : ic_mem_req_ready, 1);
        chk1("rnd other ready", own ? ic_mem_req_ready : dc_mem_req_ready, 0);
        chka("rnd req addr", mem_req_addr, rq[own].addr);
        chk1("rnd req rw", mem_req_rw, rq[own].rw);
        if (!mem_req_rw) begin
          rd_q.push_back(mem_req_addr);
          outst++;
          rd_issued[own]++;
          chk1("rnd outstanding bound", outst <= int'(MAX_OUTST), 1);
        end
        accepted[own]++;
        rq[own].pend = 0;
      end else if (ic_mem_req_ready || dc_mem_req_ready) begin
        chk1("rnd spurious req ready", 1'b1, 1'b0);
      end
      if (mem_req_data_valid && mem_req_data_ready) begin
        own = mem_req_data_bits[27];
        chk1("rnd data pending", rq[own].dpend, 1);
        chk1("rnd owner data ready", own ? dc_mem_req_data_ready : ic_mem_req_data_ready, 1);
        chk1("rnd other data ready", own ? ic_mem_req_data_ready : dc_mem_req_data_ready, 0);
        chk("rnd wdata", mem_req_data_bits, wdat(rq[own].addr));
        chk("rnd mask", {112'b0, mem_req_data_mask}, {112'b0, rq[own].addr[15:0]});
        wr_done[own]++;
        rq[own].dpend = 0;
      end else if (ic_mem_req_data_ready || dc_mem_req_data_ready) begin
        chk1("rnd spurious data ready", 1'b1, 1'b0);
      end
      step();
    end
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rnd side%0d accepted", s), 128'(accepted[s]), 128'(issued[s]));
      chk($sformatf("rnd side%0d reads done", s), 128'(rd_done[s]), 128'(rd_issued[s]));
      chk($sformatf("rnd side%0d writes done", s), 128'(wr_done[s]), 128'(wr_issued[s]));
    end
    chk("rnd reads left", 128'(rd_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
